ascon_block_packer: RTL and testbench
=====================================

Name: ascon_block_packer

Overview:
- Input-side word-to-block packer for the Ascon-AEAD128 datapath.
- Accepts a stream of 32-bit words over a valid/ready handshake and assembles them into 128-bit rate blocks.
- Applies Ascon 10* padding (byte 0x01, then zeros) to the final block, and emits an extra padding-only block when the message ends on a block boundary.
- Sits between the host data interface and the permutation/absorb logic. It is the writer feeding the core's data registers.

Parameters:
- WORD_WIDTH, 32, input word width in bits; only 32 is supported.
- BLOCK_WIDTH, 128, output block width in bits; must equal 4*WORD_WIDTH.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  reset; synchronous, active-high.
- s_valid  input  1  input word valid.
- s_ready  output  1  packer can accept a word.
- s_data  input  32  input word; byte k is s_data[8k+7:8k], little-endian.
- s_last  input  1  word is the final word of the message.
- s_nbytes  input  3  valid bytes in a last word, 0..4; ignored and treated as 4 when s_last=0.
- m_valid  output  1  output block valid.
- m_ready  input  1  consumer accepts the block.
- m_block  output  128  packed block; word i occupies bits [32i+31:32i].
- m_last  output  1  block is the final (padded) block of the message.
- m_nbytes  output  5  message bytes in the block, 0..16; padding excluded.

Behaviour:
- States: FILL, HOLD, PAD.
- Reset (sampled at a clk edge with rst=1):
  - state=FILL, word counter wcnt=0, block accumulator=0.
  - m_valid=0, m_last=0, m_nbytes=0, m_block=0.
  - s_ready=0 while rst=1, regardless of state.
- Reset mid-operation discards any partial or held block with no output. A held m_valid block is dropped.
- s_ready=1 iff state==FILL and rst=0. No input/output overlap: throughput is 4 words then at least 1 cycle of output.
- A transfer occurs when s_valid & s_ready at a rising edge. The word is written into accumulator word wcnt.
- FILL, non-last transfer:
  - wcnt<3: wcnt++.
  - wcnt==3: go to HOLD with m_valid=1, m_last=0, m_nbytes=16, no padding. Latency is 1 cycle from the 4th word's edge.
- FILL, last transfer with n=min(s_nbytes,4), total T=4*wcnt+n:
  - Bytes at index >=T are zeroed; byte T is set to 0x01 when T<16.
  - T<16: go to HOLD, m_last=1, m_nbytes=T.
  - T==16: go to HOLD, m_last=0, m_nbytes=16; after acceptance go to PAD.
- s_last with n=0 at wcnt=0 (empty message) → block=0x...01 (byte 0 = 0x01), m_last=1, m_nbytes=0.
- HOLD: m_block, m_last and m_nbytes are stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: m_valid=0, wcnt=0, accumulator cleared.
  - Next state is PAD if a full-boundary last block was just accepted, else FILL.
- PAD: for one cycle, load block=128'h01, m_last=1, m_nbytes=0, m_valid=1, then go to HOLD; the block is accepted there like any other.
- s_data and s_last are ignored when no transfer occurs.
- m_valid never deasserts without a handshake, except on rst.

Decomposition:
- Add to the shared package:
  - ASCON_RATE_WIDTH=128, ASCON_WORD_WIDTH=32 and PAD_BYTE=8'h01.
  - Typedef enum packer_state_t {FILL, HOLD, PAD}.
  - Pure function pad_block(block, nbytes) that zeroes bytes >=nbytes and inserts PAD_BYTE.
- No sub-module is needed. The FSM, counter and accumulator live in one module; padding comes from the package function.

Test Plan:
- Reset then 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (last on the 4th), m_ready=1.
  - → block 0x0F0E..0100 with m_last=0, m_nbytes=16.
  - → next block 128'h01 with m_last=1, m_nbytes=0.
- Two words 0x44332211 then 0x00776655 with s_last=1, s_nbytes=3.
  - → m_block=128'h00000000_00000000_01776655_44332211, m_last=1, m_nbytes=7.
- Single word with s_last=1, s_nbytes=0 → m_block=128'h01, m_last=1, m_nbytes=0.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid rises.
  - → m_block/m_last/m_nbytes stable and s_ready=0 throughout.
  - → after m_ready=1, one cycle later m_valid=0 and s_ready=1.
- Reset mid-fill: 2 words accepted, then rst=1 for 1 cycle.
  - → no m_valid.
  - → next 4-word message produces exactly its own data, with no stale bytes.
- Random stream of 200 messages of lengths 0..40 bytes with random s_valid/m_ready gaps → output matches a reference padding model block-for-block.

Source files
------------

// File: rtl/ascon_block_packer_pkg.sv
// Shared Ascon datapath definitions: rate/word widths, packer FSM states and 10* padding.
package ascon_block_packer_pkg;

    localparam int ASCON_RATE_WIDTH = 128;
    localparam int ASCON_WORD_WIDTH = 32;
    localparam logic [7:0] PAD_BYTE = 8'h01;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        PAD  = 2'd2
    } packer_state_t;

    // Keeps bytes below nbytes, places PAD_BYTE at index nbytes, zeroes everything above.
    // nbytes == 16 returns the block unchanged (no room for the pad byte).
    function automatic logic [ASCON_RATE_WIDTH-1:0] pad_block(
        input logic [ASCON_RATE_WIDTH-1:0] block,
        input logic [4:0]                  nbytes
    );
        logic [ASCON_RATE_WIDTH-1:0] r_out;
        r_out = '0;
        for (int i = 0; i < ASCON_RATE_WIDTH / 8; i++) begin
            if (5'(i) < nbytes) begin
                r_out[8*i +: 8] = block[8*i +: 8];
            end else if (5'(i) == nbytes) begin
                r_out[8*i +: 8] = PAD_BYTE;
            end
        end
        return r_out;
    endfunction

endpackage

// File: rtl/ascon_block_packer.sv
// Packs 32-bit words into 128-bit Ascon rate blocks with 10* padding; block valid 1 cycle after its last word.
// Input is stalled (s_ready=0) whenever a block is held or a pad-only block is being generated.
module ascon_block_packer
    import ascon_block_packer_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WORD_WIDTH-1:0]  s_data,
    input  logic                   s_last,
    input  logic [2:0]             s_nbytes,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BLOCK_WIDTH-1:0] m_block,
    output logic                   m_last,
    output logic [4:0]             m_nbytes
);

    packer_state_t          r_state,    w_state_nxt;
    logic [1:0]             r_wcnt,     w_wcnt_nxt;
    logic [BLOCK_WIDTH-1:0] r_acc,      w_acc_nxt;
    logic                   r_mvalid,   w_mvalid_nxt;
    logic                   r_mlast,    w_mlast_nxt;
    logic [4:0]             r_mnbytes,  w_mnbytes_nxt;
    logic                   r_pad_pend, w_pad_pend_nxt;

    logic                   w_xfer;
    logic [2:0]             w_n;
    logic [4:0]             w_total;
    logic [BLOCK_WIDTH-1:0] w_acc_wr;

    assign s_ready  = (r_state == FILL) && !rst;
    assign w_xfer   = s_valid && s_ready;
    assign w_n      = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
    assign w_total  = {1'b0, r_wcnt, 2'b00} + {2'b00, w_n};

    assign m_valid  = r_mvalid;
    assign m_block  = r_acc;
    assign m_last   = r_mlast;
    assign m_nbytes = r_mnbytes;

    always_comb begin
        w_acc_wr = r_acc;
        w_acc_wr[WORD_WIDTH*r_wcnt +: WORD_WIDTH] = s_data;

        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_acc_nxt      = r_acc;
        w_mvalid_nxt   = r_mvalid;
        w_mlast_nxt    = r_mlast;
        w_mnbytes_nxt  = r_mnbytes;
        w_pad_pend_nxt = r_pad_pend;

        case (r_state)
            FILL: begin
                if (w_xfer) begin
                    if (s_last) begin
                        // A message ending exactly on a block boundary owes an extra pad-only block.
                        w_acc_nxt      = pad_block(w_acc_wr, w_total);
                        w_state_nxt    = HOLD;
                        w_mvalid_nxt   = 1'b1;
                        w_mlast_nxt    = (w_total != 5'd16);
                        w_mnbytes_nxt  = w_total;
                        w_pad_pend_nxt = (w_total == 5'd16);
                    end else begin
                        w_acc_nxt = w_acc_wr;
                        if (r_wcnt == 2'd3) begin
                            w_state_nxt   = HOLD;
                            w_mvalid_nxt  = 1'b1;
                            w_mlast_nxt   = 1'b0;
                            w_mnbytes_nxt = 5'd16;
                        end else begin
                            w_wcnt_nxt = r_wcnt + 2'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (r_mvalid && m_ready) begin
                    w_state_nxt    = r_pad_pend ? PAD : FILL;
                    w_wcnt_nxt     = 2'd0;
                    w_acc_nxt      = '0;
                    w_mvalid_nxt   = 1'b0;
                    w_mlast_nxt    = 1'b0;
                    w_mnbytes_nxt  = 5'd0;
                    w_pad_pend_nxt = 1'b0;
                end
            end
            PAD: begin
                w_state_nxt   = HOLD;
                w_acc_nxt     = {{(BLOCK_WIDTH-8){1'b0}}, PAD_BYTE};
                w_mvalid_nxt  = 1'b1;
                w_mlast_nxt   = 1'b1;
                w_mnbytes_nxt = 5'd0;
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_wcnt     <= 2'd0;
            r_acc      <= '0;
            r_mvalid   <= 1'b0;
            r_mlast    <= 1'b0;
            r_mnbytes  <= 5'd0;
            r_pad_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_acc      <= w_acc_nxt;
            r_mvalid   <= w_mvalid_nxt;
            r_mlast    <= w_mlast_nxt;
            r_mnbytes  <= w_mnbytes_nxt;
            r_pad_pend <= w_pad_pend_nxt;
        end
    end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Self-checking bench for ascon_block_packer: directed scenarios plus a randomized stream against a byte-level padding model.
module tb_ascon_block_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_nbytes;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_block;
    logic         m_last;
    logic [4:0]   m_nbytes;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   cur_msg[$];
    logic [127:0] sb_blk[$];
    logic         sb_last[$];
    logic [4:0]   sb_nb[$];
    bit           drv_done;
    bit           mon_done;

    always #5 clk = ~clk;

    ascon_block_packer #(.WORD_WIDTH(32), .BLOCK_WIDTH(128)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_nbytes (s_nbytes),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_block  (m_block),
        .m_last   (m_last),
        .m_nbytes (m_nbytes)
    );

    // Reference: full 16-byte blocks, then the remainder (possibly empty) with 0x01 after the last message byte.
    task automatic model_push();
        int L;
        int r;
        logic [127:0] blk;
        L = cur_msg.size();
        for (int b = 0; b < L / 16; b++) begin
            blk = '0;
            for (int j = 0; j < 16; j++) blk[8*j +: 8] = cur_msg[16*b + j];
            sb_blk.push_back(blk);
            sb_last.push_back(1'b0);
            sb_nb.push_back(5'd16);
        end
        r = L % 16;
        blk = '0;
        for (int j = 0; j < r; j++) blk[8*j +: 8] = cur_msg[16*(L/16) + j];
        blk[8*r +: 8] = 8'h01;
        sb_blk.push_back(blk);
        sb_last.push_back(1'b1);
        sb_nb.push_back(5'(r));
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb, output bit ok);
        ok       = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = l;
        s_nbytes = nb;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = (s_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        s_valid  = 1'b0;
        s_data   = $urandom;
        s_last   = 1'($urandom_range(0, 1));
        s_nbytes = 3'($urandom_range(0, 7));
    endtask

    task automatic get_block(output bit got, output logic [127:0] b, output logic l, output logic [4:0] n);
        got = 1'b0;
        b   = '0;
        l   = 1'b0;
        n   = '0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                got = 1'b1;
                b   = m_block;
                l   = m_last;
                n   = m_nbytes;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        s_data = 32'hDEADBEEF; s_last = 1'b0; s_nbytes = 3'd4;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({m_valid, m_last, m_nbytes, m_block} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b last=%0b nb=%0d blk=%h, expected all zero", m_valid, m_last, m_nbytes, m_block);
        end
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %0b, expected 0", s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_s_ready: got %0b, expected 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_boundary();
        bit ok, ok_all, got;
        logic [127:0] b;
        logic l;
        logic [4:0] n;
        ok_all = 1'b1;
        send_word(32'h03020100, 1'b0, 3'd0, ok); ok_all &= ok;
        send_word(32'h07060504, 1'b0, 3'd0, ok); ok_all &= ok;
        send_word(32'h0B0A0908, 1'b0, 3'd0, ok); ok_all &= ok;
        send_word(32'h0F0E0D0C, 1'b1, 3'd4, ok); ok_all &= ok;
        n_checks++;
        if (!ok_all) begin n_fail++; $display("FAIL boundary_accept: words accepted=%0b, expected 1", ok_all); end
        get_block(got, b, l, n);
        n_checks++;
        if (!got || b !== 128'h0F0E0D0C_0B0A0908_07060504_03020100 || l !== 1'b0 || n !== 5'd16) begin
            n_fail++;
            $display("FAIL boundary_data_block: got(%0b) blk=%h last=%0b nb=%0d, expected blk=0f0e0d0c0b0a090807060504_03020100 last=0 nb=16", got, b, l, n);
        end
        get_block(got, b, l, n);
        n_checks++;
        if (!got || b !== 128'h01 || l !== 1'b1 || n !== 5'd0) begin
            n_fail++;
            $display("FAIL boundary_pad_block: got(%0b) blk=%h last=%0b nb=%0d, expected blk=01 last=1 nb=0", got, b, l, n);
        end
    endtask

    task automatic test_partial();
        bit ok, ok_all, got;
        logic [127:0] b;
        logic l;
        logic [4:0] n;
        ok_all = 1'b1;
        send_word(32'h44332211, 1'b0, 3'd6, ok); ok_all &= ok;
        send_word(32'h00776655, 1'b1, 3'd3, ok); ok_all &= ok;
        get_block(got, b, l, n);
        n_checks++;
        if (!ok_all || !got || b !== 128'h00000000_00000000_01776655_44332211 || l !== 1'b1 || n !== 5'd7) begin
            n_fail++;
            $display("FAIL partial_7_bytes: got(%0b,%0b) blk=%h last=%0b nb=%0d, expected blk=..01776655_44332211 last=1 nb=7", ok_all, got, b, l, n);
        end
    endtask

    task automatic test_empty();
        bit ok, got;
        logic [127:0] b;
        logic l;
        logic [4:0] n;
        send_word(32'hA5A5A5A5, 1'b1, 3'd0, ok);
        get_block(got, b, l, n);
        n_checks++;
        if (!ok || !got || b !== 128'h01 || l !== 1'b1 || n !== 5'd0) begin
            n_fail++;
            $display("FAIL empty_message: got(%0b,%0b) blk=%h last=%0b nb=%0d, expected blk=01 last=1 nb=0", ok, got, b, l, n);
        end
    endtask

    task automatic test_backpressure();
        bit ok, ok_all, got;
        logic [127:0] b, expb;
        logic l;
        logic [4:0] n;
        logic [31:0] w;
        ok_all = 1'b1;
        expb = '0;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            expb[32*k +: 32] = w;
            send_word(w, 1'b0, 3'($urandom_range(0, 7)), ok);
            ok_all &= ok;
        end
        get_block(got, b, l, n);
        n_checks++;
        if (!ok_all || !got || b !== expb || l !== 1'b0 || n !== 5'd16) begin
            n_fail++;
            $display("FAIL backpressure_block: got(%0b,%0b) blk=%h last=%0b nb=%0d, expected blk=%h last=0 nb=16", ok_all, got, b, l, n, expb);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_block !== expb || m_last !== 1'b0 || m_nbytes !== 5'd16 || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: valid=%0b blk=%h last=%0b nb=%0d s_ready=%0b, expected 1/%h/0/16/0", c, m_valid, m_block, m_last, m_nbytes, s_ready, expb);
            end
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%0b s_ready=%0b, expected valid=0 s_ready=1", m_valid, s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midfill();
        bit ok, ok_all, got;
        int seen;
        logic [127:0] b, expb;
        logic l;
        logic [4:0] n;
        logic [31:0] w;
        send_word(32'hFFEEDDCC, 1'b0, 3'd4, ok);
        send_word(32'hBBAA9988, 1'b0, 3'd4, ok);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL midfill_reset_s_ready: got %0b, expected 0", s_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL midfill_no_output: valid cycles=%0d, expected 0", seen); end
        ok_all = 1'b1;
        expb = '0;
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            expb[32*k +: 32] = w;
            send_word(w, (k == 3), 3'd4, ok);
            ok_all &= ok;
        end
        get_block(got, b, l, n);
        n_checks++;
        if (!ok_all || !got || b !== expb || l !== 1'b0 || n !== 5'd16) begin
            n_fail++;
            $display("FAIL midfill_fresh_block: got(%0b,%0b) blk=%h last=%0b nb=%0d, expected blk=%h last=0 nb=16", ok_all, got, b, l, n, expb);
        end
        get_block(got, b, l, n);
        n_checks++;
        if (!got || b !== 128'h01 || l !== 1'b1 || n !== 5'd0) begin
            n_fail++;
            $display("FAIL midfill_pad_block: got(%0b) blk=%h last=%0b nb=%0d, expected blk=01 last=1 nb=0", got, b, l, n);
        end
    endtask

    task automatic test_random();
        drv_done = 1'b0;
        mon_done = 1'b0;
        fork
            begin : driver
                int L, nw, nwords, nb_i;
                bit extra, lst, ok, abort;
                logic [31:0] w;
                logic [2:0] nb;
                abort = 1'b0;
                for (int m = 0; m < 200 && !abort; m++) begin
                    L = $urandom_range(0, 40);
                    cur_msg.delete();
                    for (int i = 0; i < L; i++) cur_msg.push_back(8'($urandom));
                    model_push();
                    nw = (L + 3) / 4;
                    if (nw == 0) nw = 1;
                    extra  = (L > 0) && (L % 4 == 0) && ($urandom_range(0, 3) == 0);
                    nwords = nw + (extra ? 1 : 0);
                    for (int k = 0; k < nwords && !abort; k++) begin
                        w = $urandom;
                        if (k < nw) begin
                            for (int j = 0; j < 4; j++) if (4*k + j < L) w[8*j +: 8] = cur_msg[4*k + j];
                            if (k == nw - 1 && !extra) begin
                                lst  = 1'b1;
                                nb_i = L - 4*k;
                                nb   = (nb_i == 4) ? 3'(4 + $urandom_range(0, 3)) : 3'(nb_i);
                            end else begin
                                lst = 1'b0;
                                nb  = 3'($urandom_range(0, 7));
                            end
                        end else begin
                            lst = 1'b1;
                            nb  = 3'd0;
                        end
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) @(posedge clk);
                            #1;
                        end
                        send_word(w, lst, nb, ok);
                        n_checks++;
                        if (!ok) begin
                            n_fail++;
                            abort = 1'b1;
                            $display("FAIL random_accept msg %0d word %0d: accepted=%0b, expected 1", m, k, ok);
                        end
                    end
                end
                drv_done = 1'b1;
            end
            begin : monitor
                int cyc;
                logic [127:0] eb;
                logic el;
                logic [4:0] en;
                cyc = 0;
                while (!(drv_done && sb_blk.size() == 0) && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    if (m_valid === 1'b1 && m_ready === 1'b1) begin
                        n_checks++;
                        if (sb_blk.size() == 0) begin
                            n_fail++;
                            $display("FAIL random_unexpected_block: blk=%h last=%0b nb=%0d, expected no block", m_block, m_last, m_nbytes);
                        end else begin
                            eb = sb_blk.pop_front();
                            el = sb_last.pop_front();
                            en = sb_nb.pop_front();
                            if (m_block !== eb || m_last !== el || m_nbytes !== en) begin
                                n_fail++;
                                $display("FAIL random_block: got blk=%h last=%0b nb=%0d, expected blk=%h last=%0b nb=%0d", m_block, m_last, m_nbytes, eb, el, en);
                            end
                        end
                    end
                end
                n_checks++;
                if (cyc >= 60000) begin
                    n_fail++;
                    $display("FAIL random_timeout: pending blocks=%0d, expected 0", sb_blk.size());
                end
                mon_done = 1'b1;
            end
            begin : ready_toggler
                while (!mon_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 2) != 0);
                end
                m_ready = 1'b1;
            end
        join
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0; m_ready = 1'b1;
        test_reset();
        test_full_boundary();
        test_partial();
        test_empty();
        test_backpressure();
        test_reset_midfill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
